// File: rtl/lsu_stb_alloc_ctl_if.sv
// lsu_stb_alloc_ctl_if: store-buffer allocation control bundle (requests in, pointers/status out).
// Rev 1.0
`default_nettype none

interface lsu_stb_alloc_ctl_if;
   logic       st_wr_m;
   logic       st_kill_w;
   logic       stb_issue;
   logic       stb_ack;
   logic [7:0] stb_clk_en_l;
   logic [2:0] stb_wr_ptr;
   logic [2:0] stb_iss_ptr;
   logic [2:0] stb_rd_ptr;
   logic [7:0] stb_valid;
   logic [3:0] stb_cnt;
   logic       stb_full;
   logic       stb_empty;
   logic       stb_pend;
   logic       stb_err;

   modport master (
      output st_wr_m, st_kill_w, stb_issue, stb_ack,
      input  stb_clk_en_l, stb_wr_ptr, stb_iss_ptr, stb_rd_ptr,
      input  stb_valid, stb_cnt, stb_full, stb_empty, stb_pend, stb_err
   );

   modport slave (
      input  st_wr_m, st_kill_w, stb_issue, stb_ack,
      output stb_clk_en_l, stb_wr_ptr, stb_iss_ptr, stb_rd_ptr,
      output stb_valid, stb_cnt, stb_full, stb_empty, stb_pend, stb_err
   );
endinterface

`default_nettype wire

// File: rtl/lsu_stb_alloc_ctl.sv
// lsu_stb_alloc_ctl: 8-entry store-buffer allocate/issue/retire pointer and status controller.
// Rev 1.0
`default_nettype none

module lsu_stb_alloc_ctl (
   input  wire logic           rclk,
   input  wire logic           rst,
   lsu_stb_alloc_ctl_if.slave  stb
);

   logic [2:0] r_wr_ptr;
   logic [2:0] r_iss_ptr;
   logic [2:0] r_rd_ptr;
   logic [2:0] r_last_slot;
   logic [7:0] r_valid;
   logic [7:0] r_issued;
   logic [3:0] r_cnt;
   logic       r_last_wr;
   logic       r_err;

   logic       w_full;
   logic       w_kill_eff;
   logic       w_wr_acc;
   logic [2:0] w_tgt;
   logic [7:0] w_tgt_oh;
   logic       w_committed;
   logic       w_pend;
   logic       w_iss_ok;
   logic       w_ack_ok;
   logic       w_err;
   logic       w_cnt_inc;
   logic       w_cnt_dec;
   logic [7:0] w_valid_nxt;
   logic [7:0] w_issued_nxt;

   assign w_full     = (r_cnt == 4'd8);
   assign w_kill_eff = stb.st_kill_w & r_last_wr;
   assign w_wr_acc   = stb.st_wr_m & (~w_full | w_kill_eff);
   // A kill with a coincident write overwrites the killed slot in place.
   assign w_tgt      = w_kill_eff ? (r_wr_ptr - 3'd1) : r_wr_ptr;
   assign w_tgt_oh   = 8'b0000_0001 << w_tgt;

   assign w_committed = r_valid[r_iss_ptr] & ~(r_last_wr & (r_iss_ptr == r_last_slot));
   assign w_pend      = w_committed & ~r_issued[r_iss_ptr];
   assign w_iss_ok    = stb.stb_issue & w_pend;
   assign w_ack_ok    = stb.stb_ack & r_valid[r_rd_ptr] & r_issued[r_rd_ptr];

   assign w_err = (stb.st_wr_m & ~w_wr_acc)
                | (stb.st_kill_w & ~r_last_wr)
                | (stb.stb_issue & ~w_pend)
                | (stb.stb_ack & ~w_ack_ok);

   assign w_cnt_inc = w_wr_acc & ~w_kill_eff;
   assign w_cnt_dec = w_kill_eff & ~w_wr_acc;

   always_comb begin
      w_valid_nxt  = r_valid;
      w_issued_nxt = r_issued;
      if (w_ack_ok) begin
         w_valid_nxt[r_rd_ptr]  = 1'b0;
         w_issued_nxt[r_rd_ptr] = 1'b0;
      end
      if (w_cnt_dec)
         w_valid_nxt[r_last_slot] = 1'b0;
      if (w_wr_acc)
         w_valid_nxt[w_tgt] = 1'b1;
      if (w_iss_ok)
         w_issued_nxt[r_iss_ptr] = 1'b1;
   end

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= 3'd0;
         r_iss_ptr   <= 3'd0;
         r_rd_ptr    <= 3'd0;
         r_last_slot <= 3'd0;
         r_valid     <= 8'h00;
         r_issued    <= 8'h00;
         r_cnt       <= 4'd0;
         r_last_wr   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_valid  <= w_valid_nxt;
         r_issued <= w_issued_nxt;
         r_err    <= w_err;
         r_cnt    <= r_cnt + {3'd0, w_cnt_inc} - {3'd0, w_cnt_dec} - {3'd0, w_ack_ok};
         r_last_wr <= w_wr_acc;
         if (w_wr_acc)
            r_last_slot <= w_tgt;
         if (w_cnt_inc)
            r_wr_ptr <= r_wr_ptr + 3'd1;
         else if (w_cnt_dec)
            r_wr_ptr <= r_wr_ptr - 3'd1;
         if (w_iss_ok)
            r_iss_ptr <= r_iss_ptr + 3'd1;
         if (w_ack_ok)
            r_rd_ptr <= r_rd_ptr + 3'd1;
      end
   end

   // Enables are gated by rst so an in-flight write is never captured during reset.
   assign stb.stb_clk_en_l = (w_wr_acc & ~rst) ? ~w_tgt_oh : 8'hFF;
   assign stb.stb_wr_ptr   = r_wr_ptr;
   assign stb.stb_iss_ptr  = r_iss_ptr;
   assign stb.stb_rd_ptr   = r_rd_ptr;
   assign stb.stb_valid    = r_valid;
   assign stb.stb_cnt      = r_cnt;
   assign stb.stb_full     = w_full;
   assign stb.stb_empty    = (r_cnt == 4'd0);
   assign stb.stb_pend     = w_pend;
   assign stb.stb_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_stb_alloc_ctl.sv
// tb_lsu_stb_alloc_ctl: directed self-checking bench for the store-buffer allocation controller.
// Rev 1.0
`default_nettype none

module tb_lsu_stb_alloc_ctl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   lsu_stb_alloc_ctl_if u_if ();

   lsu_stb_alloc_ctl u_dut (
      .rclk (clk),
      .rst  (rst),
      .stb  (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic kill, input logic iss, input logic ack);
      u_if.st_wr_m   = wr;
      u_if.st_kill_w = kill;
      u_if.stb_issue = iss;
      u_if.stb_ack   = ack;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;

      chk("rst_wr_ptr",  {5'd0, u_if.stb_wr_ptr},  8'h00);
      chk("rst_iss_ptr", {5'd0, u_if.stb_iss_ptr}, 8'h00);
      chk("rst_rd_ptr",  {5'd0, u_if.stb_rd_ptr},  8'h00);
      chk("rst_valid",   u_if.stb_valid,           8'h00);
      chk("rst_cnt",     {4'd0, u_if.stb_cnt},     8'h00);
      chk("rst_empty",   {7'd0, u_if.stb_empty},   8'h01);
      chk("rst_full",    {7'd0, u_if.stb_full},    8'h00);
      chk("rst_pend",    {7'd0, u_if.stb_pend},    8'h00);
      chk("rst_err",     {7'd0, u_if.stb_err},     8'h00);
      chk("rst_clken",   u_if.stb_clk_en_l,        8'hFF);

      // Three back-to-back writes
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("w3_clken0", u_if.stb_clk_en_l, 8'hFE);
      tick();
      #1 chk("w3_clken1", u_if.stb_clk_en_l, 8'hFD);
      chk("w3_pend_n1", {7'd0, u_if.stb_pend}, 8'h00);
      tick();
      #1 chk("w3_clken2", u_if.stb_clk_en_l, 8'hFB);
      chk("w3_pend_n2", {7'd0, u_if.stb_pend}, 8'h01);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("w3_wr_ptr", {5'd0, u_if.stb_wr_ptr}, 8'h03);
      chk("w3_cnt",    {4'd0, u_if.stb_cnt},    8'h03);
      chk("w3_valid",  u_if.stb_valid,          8'h07);
      chk("w3_empty",  {7'd0, u_if.stb_empty},  8'h00);

      // Write then kill alone
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("k_clken", u_if.stb_clk_en_l, 8'hFF);
      chk("k_pend_a", {7'd0, u_if.stb_pend}, 8'h00);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("k_valid",  u_if.stb_valid,          8'h00);
      chk("k_wr_ptr", {5'd0, u_if.stb_wr_ptr}, 8'h00);
      chk("k_cnt",    {4'd0, u_if.stb_cnt},    8'h00);
      chk("k_err",    {7'd0, u_if.stb_err},    8'h00);
      chk("k_pend_b", {7'd0, u_if.stb_pend},   8'h00);
      tick();
      chk("k_pend_c", {7'd0, u_if.stb_pend},   8'h00);

      // Write then kill with a coincident write reusing slot 0
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      #1 chk("kw_clken", u_if.stb_clk_en_l, 8'hFE);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("kw_wr_ptr", {5'd0, u_if.stb_wr_ptr}, 8'h01);
      chk("kw_cnt",    {4'd0, u_if.stb_cnt},    8'h01);
      chk("kw_valid",  u_if.stb_valid,          8'h01);
      chk("kw_err",    {7'd0, u_if.stb_err},    8'h00);

      // Fill, overflow attempt, drain one, wrap
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      chk("f_full",   {7'd0, u_if.stb_full},   8'h01);
      chk("f_cnt",    {4'd0, u_if.stb_cnt},    8'h08);
      chk("f_wr_ptr", {5'd0, u_if.stb_wr_ptr}, 8'h00);
      chk("f_valid",  u_if.stb_valid,          8'hFF);
      #1 chk("f_clken_ovf", u_if.stb_clk_en_l, 8'hFF);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("f_err_ovf", {7'd0, u_if.stb_err},    8'h01);
      chk("f_cnt_ovf", {4'd0, u_if.stb_cnt},    8'h08);
      chk("f_wp_ovf",  {5'd0, u_if.stb_wr_ptr}, 8'h00);
      tick();
      chk("f_err_clr", {7'd0, u_if.stb_err},    8'h00);
      chk("f_pend",    {7'd0, u_if.stb_pend},   8'h01);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("f_cnt_dr",  {4'd0, u_if.stb_cnt},     8'h07);
      chk("f_full_dr", {7'd0, u_if.stb_full},    8'h00);
      chk("f_rd_ptr",  {5'd0, u_if.stb_rd_ptr},  8'h01);
      chk("f_iss_ptr", {5'd0, u_if.stb_iss_ptr}, 8'h01);
      chk("f_err_dr",  {7'd0, u_if.stb_err},     8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("f_clken_wrap", u_if.stb_clk_en_l, 8'hFE);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("f_wp_wrap",   {5'd0, u_if.stb_wr_ptr}, 8'h01);
      chk("f_cnt_wrap",  {4'd0, u_if.stb_cnt},    8'h08);
      chk("f_full_wrap", {7'd0, u_if.stb_full},   8'h01);

      // Write + issue + ack in one cycle
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      #1 chk("x_clken", u_if.stb_clk_en_l, 8'hFB);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("x_cnt",     {4'd0, u_if.stb_cnt},     8'h02);
      chk("x_rd_ptr",  {5'd0, u_if.stb_rd_ptr},  8'h01);
      chk("x_iss_ptr", {5'd0, u_if.stb_iss_ptr}, 8'h02);
      chk("x_wr_ptr",  {5'd0, u_if.stb_wr_ptr},  8'h03);
      chk("x_valid",   u_if.stb_valid,           8'h06);
      chk("x_err",     {7'd0, u_if.stb_err},     8'h00);

      // Protocol violations
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("e_ack_err", {7'd0, u_if.stb_err},    8'h01);
      chk("e_ack_rd",  {5'd0, u_if.stb_rd_ptr}, 8'h00);
      chk("e_ack_cnt", {4'd0, u_if.stb_cnt},    8'h00);
      tick();
      chk("e_err_clr", {7'd0, u_if.stb_err},    8'h00);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("e_iss_err", {7'd0, u_if.stb_err},     8'h01);
      chk("e_iss_ptr", {5'd0, u_if.stb_iss_ptr}, 8'h00);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("e_kill_err",   {7'd0, u_if.stb_err},    8'h01);
      chk("e_kill_wp",    {5'd0, u_if.stb_wr_ptr}, 8'h00);
      chk("e_kill_valid", u_if.stb_valid,          8'h00);

      // Asynchronous reset in the middle of a write burst
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      chk("r_pre_cnt", {4'd0, u_if.stb_cnt}, 8'h03);
      #2 rst = 1'b1;
      #1;
      chk("r_clken", u_if.stb_clk_en_l,        8'hFF);
      chk("r_wp",    {5'd0, u_if.stb_wr_ptr},  8'h00);
      chk("r_cnt",   {4'd0, u_if.stb_cnt},     8'h00);
      chk("r_valid", u_if.stb_valid,           8'h00);
      chk("r_empty", {7'd0, u_if.stb_empty},   8'h01);
      chk("r_pend",  {7'd0, u_if.stb_pend},    8'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_stb_alloc_ctl.md
# lsu_stb_alloc_ctl

Per-thread allocation and retirement controller for the 8-entry store-buffer state array (va[7:6], rq_type, rmo per entry). It owns the circular write, issue and retire pointers. It generates the one-hot active-low per-entry clock enables that capture M-stage store state. It also tracks valid, issued and committed status, and handles W-stage kill of the youngest store and L2 acknowledgement of the oldest.

## Interface
Parameters: none (depth fixed at 8; pointers 3 bits, count 4 bits).
- rclk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- st_wr_m  in  1  M-stage store requests an entry
- st_kill_w  in  1  kill the store written in the previous cycle
- stb_issue  in  1  PCX has taken the entry at stb_iss_ptr
- stb_ack  in  1  L2 ack; retire entry at stb_rd_ptr
- stb_clk_en_l  out  8  per-entry write enable, active low, one-hot or all-ones
- stb_wr_ptr  out  3  next allocation entry
- stb_iss_ptr  out  3  oldest committed, unissued entry
- stb_rd_ptr  out  3  oldest valid entry
- stb_valid  out  8  per-entry valid
- stb_cnt  out  4  valid entries, 0..8
- stb_full  out  1  stb_cnt==8
- stb_empty  out  1  stb_cnt==0
- stb_pend  out  1  a committed, unissued entry exists at stb_iss_ptr
- stb_err  out  1  one-cycle pulse on protocol violation

## Operation
- Reset values: all pointers 0, stb_valid 0, stb_cnt 0, stb_empty 1, stb_full 0, stb_pend 0, stb_err 0, stb_clk_en_l 8'hFF. Internal last_wr flag 0.
- Write accept: wr_acc = st_wr_m & (~stb_full | kill_eff).
  - Target slot is stb_wr_ptr, or stb_wr_ptr-1 when kill_eff (see below).
  - stb_clk_en_l is combinational: the target bit is 0 when wr_acc, all other bits are 1.
  - At the edge: target valid is set, last_wr<=1, last_slot<=target, and stb_wr_ptr increments (mod 8) unless kill_eff.
- Write refused: st_wr_m while full and not kill_eff leaves all state unchanged and pulses stb_err. stb_clk_en_l stays all ones.
- Kill: kill_eff = st_kill_w & last_wr.
  - Without a coincident write, valid[last_slot] clears and stb_wr_ptr decrements (mod 8).
  - With a coincident write, the new store reuses last_slot and valid stays 1.
  - st_kill_w with last_wr=0 is ignored and pulses stb_err.
  - last_wr<=0 whenever there is no accepted write this cycle.
- Commit: an entry is committed once it is valid and not (last_wr & slot==last_slot).
- Issue: stb_pend = valid[iss_ptr] & ~issued[iss_ptr] & committed.
  - stb_issue with stb_pend sets issued[iss_ptr] and increments iss_ptr.
  - stb_issue without stb_pend is ignored and pulses stb_err.
- Ack: legal only when valid[rd_ptr] & issued[rd_ptr].
  - A legal ack clears valid and issued at rd_ptr and increments rd_ptr.
  - Otherwise it is ignored and pulses stb_err.
- Count: stb_cnt next = stb_cnt + wr_acc&~kill_eff − (kill_eff&~wr_acc) − ack_legal. Range is 0..8 and saturation never occurs under legal use.
- Simultaneous events in one cycle are all legal: write + ack, write + issue + ack, kill + issue (issue sees only committed entries).
  - Write + ack when full is not accepted; full is sampled before the ack.
- Reset mid-operation: asynchronous clear of all state. stb_clk_en_l returns to all ones immediately, so no entry is captured.
- Wrap-around: all pointers are mod 8. Full and empty are derived from stb_cnt, never from pointer equality.

## Timing
- stb_clk_en_l is combinational from st_wr_m, st_kill_w and registered state. The entry captures on the same rclk edge the write is accepted.
- All other outputs are registered and update one edge after the causing input.
- Write-to-issue: minimum 2 cycles. An entry written at edge N is kill-eligible in cycle N+1 and is committed and pend-visible in cycle N+2.
- Issue-to-ack: no minimum; an ack may arrive the cycle after the issue.
- stb_err is asserted for exactly the cycle after the offending input.

## Test plan
- Reset then three writes in consecutive cycles -> stb_clk_en_l = FE, FD, FB; stb_wr_ptr=3, stb_cnt=3, stb_valid=07, stb_pend=1 two cycles after the first write.
- Write slot 0, st_kill_w next cycle with no write -> stb_valid=00, stb_wr_ptr=0, stb_cnt=0, stb_pend never 1.
- Write slot 0, then a cycle with st_wr_m and st_kill_w together -> stb_clk_en_l=FE again, stb_wr_ptr=1, stb_cnt=1.
- Fill 8 entries -> stb_full=1; a 9th write gives stb_clk_en_l=FF and stb_err pulse; issue+ack entry 0 -> next write hits FE with wr_ptr wrapping to 1.
- Issue 1 entry, then in one cycle assert write, issue and ack -> stb_cnt unchanged, rd_ptr+1, iss_ptr+1, wr_ptr+1.
- Ack with nothing issued, issue when stb_pend=0, kill with no prior write -> each gives one stb_err pulse and no state change; assert rst mid-burst -> all outputs at reset values asynchronously.
